// File: rtl/env_pkg.sv
`default_nettype none
// ============================================================================
// Module      : env_pkg
// Description : Shared definitions for the ADSR envelope controller:
//               envelope state encodings and level width/limit constants.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package env_pkg;

    // Envelope states; encodings are visible on the env_state port.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } env_state_e;

    localparam int LEVEL_W   = 9;    // level spans 0..256 inclusive
    localparam int LEVEL_MAX = 256;  // unity gain

endpackage : env_pkg
`default_nettype wire

// File: rtl/env_tick.sv
`default_nettype none
// ============================================================================
// Module      : env_tick
// Description : Free-running divider producing a one-cycle envelope update
//               strobe every TICK_DIV clock cycles. Only reset restarts it.
// Ports       : clk   - system clock
//               rst_n - synchronous active-low reset
//               tick  - high for one cycle when the count reaches TICK_DIV-1
// Revision    : 1.0 - initial release
// ============================================================================
module env_tick #(
    parameter int TICK_DIV = 12000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int                CNT_W  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0]  c_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q + CNT_W'(1);
        if (count_q == c_LAST) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick = (count_q == c_LAST);

endmodule : env_tick
`default_nettype wire

// File: rtl/envelope_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : envelope_ctrl
// Description : ADSR envelope sequencer driven by a key gate, plus the gain
//               stage that scales the sample stream by the envelope level.
// Ports       : clk        - system clock
//               rst_n      - synchronous active-low reset
//               key_on     - key gate, synchronous and debounced, high=pressed
//               sample_in  - 10-bit unsigned sample
//               dac_data   - registered gained sample (sample*level)>>8
//               level      - current envelope level, 0..256
//               env_state  - current state encoding
//               env_active - high whenever the envelope is not IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module envelope_ctrl
    import env_pkg::*;
#(
    parameter int TICK_DIV      = 12000,
    parameter int ATTACK_STEP   = 4,
    parameter int DECAY_STEP    = 1,
    parameter int SUSTAIN_LEVEL = 160,
    parameter int RELEASE_STEP  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               key_on,
    input  logic [9:0]         sample_in,
    output logic [9:0]         dac_data,
    output logic [LEVEL_W-1:0] level,
    output logic [2:0]         env_state,
    output logic               env_active
);

    // Level arithmetic is carried one bit wider so level+step cannot wrap.
    localparam logic [9:0] c_ATTACK_STEP  = 10'(ATTACK_STEP);
    localparam logic [9:0] c_DECAY_STEP   = 10'(DECAY_STEP);
    localparam logic [9:0] c_RELEASE_STEP = 10'(RELEASE_STEP);
    localparam logic [9:0] c_SUSTAIN      = 10'(SUSTAIN_LEVEL);
    localparam logic [9:0] c_LEVEL_MAX    = 10'(LEVEL_MAX);

    env_state_e         state_q, state_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic               key_d_q;
    logic [9:0]         dac_q, dac_d;

    logic       tick;
    logic       key_rise;
    logic [9:0] level_ext;
    logic [9:0] level_next;
    logic [18:0] product;

    env_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_env_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    assign key_rise  = key_on & ~key_d_q;
    assign level_ext = {1'b0, level_q};

    // Next-state: a fresh key press always restarts ATTACK from the current
    // level, key release beats any level-driven transition.
    always_comb begin
        state_d = state_q;
        if (key_rise) begin
            state_d = ST_ATTACK;
        end else if (!key_on && (state_q == ST_ATTACK || state_q == ST_DECAY ||
                                 state_q == ST_SUSTAIN)) begin
            state_d = ST_RELEASE;
        end else begin
            case (state_q)
                ST_ATTACK:  if (level_ext == c_LEVEL_MAX) state_d = ST_DECAY;
                ST_DECAY:   if (level_ext == c_SUSTAIN)   state_d = ST_SUSTAIN;
                ST_RELEASE: if (level_q == '0)            state_d = ST_IDLE;
                default:    state_d = state_q;
            endcase
        end
    end

    // Level step uses the registered state, so a tick coinciding with a key
    // event still applies the old state's rule. Subtractions compare first
    // so they never underflow.
    always_comb begin
        level_next = level_ext;
        case (state_q)
            ST_ATTACK: begin
                level_next = level_ext + c_ATTACK_STEP;
                if (level_next >= c_LEVEL_MAX) level_next = c_LEVEL_MAX;
            end
            ST_DECAY: begin
                if (level_ext >= c_SUSTAIN + c_DECAY_STEP) level_next = level_ext - c_DECAY_STEP;
                else                                       level_next = c_SUSTAIN;
            end
            ST_RELEASE: begin
                if (level_ext >= c_RELEASE_STEP) level_next = level_ext - c_RELEASE_STEP;
                else                             level_next = '0;
            end
            default: level_next = level_ext;
        endcase
        level_d = tick ? LEVEL_W'(level_next) : level_q;
    end

    // 1023*256 < 2^18, so bits [17:8] hold the whole scaled result.
    always_comb begin
        product = 19'(sample_in) * 19'(level_q);
        dac_d   = 10'(product >> 8);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            level_q <= '0;
            key_d_q <= 1'b0;
            dac_q   <= '0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            key_d_q <= key_on;
            dac_q   <= dac_d;
        end
    end

    assign dac_data   = dac_q;
    assign level      = level_q;
    assign env_state  = state_q;
    assign env_active = (state_q != ST_IDLE);

endmodule : envelope_ctrl
`default_nettype wire
